// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//
// Receive-side timing decoder for a VGA link driven from the same pixel clock.
// Registers the incoming sync/video/RGB once (S1), then derives pixel
// coordinates, measures line and frame geometry against the configured mode,
// counts timing errors, and declares lock after LOCK_FRAMES clean frames.
//
// Optional feature macro: VGA_RX_CHECKSUM_EN
//   defined   : 16-bit wrapping per-frame RGB checksum on frame_sum
//   undefined : frame_sum tied to zero
//
// Parameters:
//   H_DISPLAY   active pixels per line
//   H_TOTAL     clocks per line
//   H_SYNC      hsync low width in clocks
//   V_DISPLAY   active lines per frame
//   V_TOTAL     lines per frame
//   LOCK_FRAMES consecutive clean frames required for lock (1..15)
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high
//   hsync_in     horizontal sync, active low
//   vsync_in     vertical sync, active low
//   video_on_in  active-video qualifier
//   rgb_in       {red[3:0], green[3:0], blue[3:0]}
//   pixel_valid  active pixel present on x_pos/y_pos/rgb_out
//   x_pos        active pixel column
//   y_pos        active line index
//   rgb_out      pixel data aligned with pixel_valid
//   frame_start  one-cycle pulse on vsync assertion
//   locked       timing locked
//   err_pulse    one-cycle pulse per cycle with any counted check failure
//   err_count    saturating error count
//   line_len     last measured hsync-fall-to-fall period
//   frame_sum    last frame RGB checksum
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_on_in,
  input  logic [11:0] rgb_in,
  output logic        pixel_valid,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic [10:0] line_len,
  output logic [15:0] frame_sum
);

  localparam logic [10:0] C_H_TOTAL = 11'(H_TOTAL);
  localparam logic [10:0] C_H_SYNC  = 11'(H_SYNC);
  localparam logic [10:0] C_H_DISP  = 11'(H_DISPLAY);
  localparam logic [10:0] C_TIMEOUT = 11'(2 * H_TOTAL);
  localparam logic [10:0] C_V_TOTAL = 11'(V_TOTAL);
  localparam logic [10:0] C_V_DISP  = 11'(V_DISPLAY);
  localparam logic [3:0]  C_LOCK    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage S1 input registers and their previous values for edge detection.
  // Syncs idle high so reset does not fake an edge.
  // ---------------------------------------------------------------------------
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_von;
  logic [11:0] r_s1_rgb;
  logic        r_s1_hs_d;
  logic        r_s1_vs_d;
  logic        r_s1_von_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s1_von   <= 1'b0;
      r_s1_rgb   <= '0;
      r_s1_hs_d  <= 1'b1;
      r_s1_vs_d  <= 1'b1;
      r_s1_von_d <= 1'b0;
    end else begin
      r_s1_hs    <= hsync_in;
      r_s1_vs    <= vsync_in;
      r_s1_von   <= video_on_in;
      r_s1_rgb   <= rgb_in;
      r_s1_hs_d  <= r_s1_hs;
      r_s1_vs_d  <= r_s1_vs;
      r_s1_von_d <= r_s1_von;
    end
  end

  logic w_hs_fall;
  logic w_hs_rise;
  logic w_vs_fall;
  logic w_von_rise;
  logic w_von_fall;

  assign w_hs_fall  =  r_s1_hs_d  & ~r_s1_hs;
  assign w_hs_rise  = ~r_s1_hs_d  &  r_s1_hs;
  assign w_vs_fall  =  r_s1_vs_d  & ~r_s1_vs;
  assign w_von_rise = ~r_s1_von_d &  r_s1_von;
  assign w_von_fall =  r_s1_von_d & ~r_s1_von;

  // ---------------------------------------------------------------------------
  // Geometry counters
  // ---------------------------------------------------------------------------
  logic [10:0] r_period;
  logic        r_period_vld;
  logic        r_to_armed;
  logic [10:0] r_width;
  logic        r_width_vld;
  logic [10:0] r_act;
  logic        r_act_vld;
  logic [10:0] r_lines;
  logic [10:0] r_act_lines;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_to_armed   <= 1'b1;
      r_width      <= '0;
      r_width_vld  <= 1'b0;
      r_act        <= '0;
      r_act_vld    <= 1'b0;
      r_lines      <= '0;
      r_act_lines  <= '0;
    end else begin
      // Period counter: 1 in the cycle after a fall, so at the next fall it
      // holds the exact fall-to-fall distance; sticks at all-ones.
      if (w_hs_fall) begin
        r_period     <= 11'd1;
        r_period_vld <= 1'b1;
      end else if (r_period != '1) begin
        r_period <= r_period + 11'd1;
      end

      // Timeout fires once per stall and rearms only on a real hsync fall.
      if (w_hs_fall) begin
        r_to_armed <= 1'b1;
      end else if (r_to_armed && (r_period == C_TIMEOUT)) begin
        r_to_armed <= 1'b0;
      end

      if (w_hs_fall) begin
        r_width     <= 11'd1;
        r_width_vld <= 1'b1;
      end else if (!r_s1_hs && (r_width != '1)) begin
        r_width <= r_width + 11'd1;
      end

      if (w_von_rise) begin
        r_act     <= 11'd1;
        r_act_vld <= 1'b1;
      end else if (r_s1_von && (r_act != '1)) begin
        r_act <= r_act + 11'd1;
      end

      // An hsync/video_on fall coincident with vsync fall opens the new frame.
      if (w_vs_fall) begin
        r_lines <= w_hs_fall ? 11'd1 : 11'd0;
      end else if (w_hs_fall && (r_lines != '1)) begin
        r_lines <= r_lines + 11'd1;
      end

      if (w_vs_fall) begin
        r_act_lines <= w_von_fall ? 11'd1 : 11'd0;
      end else if (w_von_fall && (r_act_lines != '1)) begin
        r_act_lines <= r_act_lines + 11'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checks
  // ---------------------------------------------------------------------------
  logic w_err_len;
  logic w_err_width;
  logic w_err_act;
  logic w_err_frame;
  logic w_err_to;
  logic w_err_any;
  logic w_err_cnt;

  assign w_err_len   = w_hs_fall & r_period_vld & (r_period != C_H_TOTAL);
  assign w_err_width = w_hs_rise & r_width_vld & (r_width != C_H_SYNC);
  assign w_err_act   = w_von_fall & r_act_vld & (r_act != C_H_DISP);
  assign w_err_frame = w_vs_fall &
                       ((r_lines != C_V_TOTAL) | (r_act_lines != C_V_DISP));
  assign w_err_to    = r_to_armed & (r_period == C_TIMEOUT);
  assign w_err_any   = w_err_len | w_err_width | w_err_act | w_err_frame | w_err_to;

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_good;
  logic [3:0] w_good_nxt;
  logic [3:0] w_good_inc;
  logic       r_frame_err;
  logic       w_frame_err_nxt;

  assign w_good_inc = r_good + 4'd1;
  assign w_err_cnt  = w_err_any & (r_state != ST_SEARCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SEARCH;
      r_good      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_good_nxt      = r_good;
    w_frame_err_nxt = r_frame_err;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt     = ST_ACQUIRE;
          w_good_nxt      = '0;
          w_frame_err_nxt = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (w_vs_fall) begin
          // An error in the vsync-fall cycle belongs to the frame that ends.
          w_frame_err_nxt = 1'b0;
          if (r_frame_err || w_err_any) begin
            w_good_nxt = '0;
          end else begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == C_LOCK) begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end else if (w_err_any) begin
          w_frame_err_nxt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_err_any) begin
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_good_nxt  = '0;
      end
    endcase
  end

  assign locked = (r_state == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // Output stage (S2)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      line_len    <= '0;
    end else begin
      pixel_valid <= r_s1_von;
      rgb_out     <= r_s1_rgb;
      frame_start <= w_vs_fall;
      err_pulse   <= w_err_cnt;

      if (w_von_rise) begin
        x_pos <= '0;
      end else if (r_s1_von) begin
        x_pos <= x_pos + 10'd1;
      end

      if (w_vs_fall) begin
        y_pos <= '0;
      end else if (w_von_fall) begin
        y_pos <= y_pos + 10'd1;
      end

      if (w_err_cnt && (err_count != '1)) begin
        err_count <= err_count + 8'd1;
      end

      if (w_hs_fall) begin
        line_len <= r_period;
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum    <= '0;
      frame_sum <= '0;
    end else if (w_vs_fall) begin
      frame_sum <= r_csum;
      r_csum    <= r_s1_von ? {4'd0, r_s1_rgb} : 16'd0;
    end else if (r_s1_von) begin
      r_csum <= r_csum + {4'd0, r_s1_rgb};
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule
